rng_arbiter: RTL and testbench

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rng_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// Round-robin arbiter that serves four requesters from one shared random
// generator, rejection-sampling each value against the requester's limit.
module rng_arbiter #(
   parameter int unsigned MAX_RETRY = 15,
   parameter int unsigned WAIT_MAX  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] lim,
   output logic [3:0]  gnt,
   output logic [7:0]  value,
   output logic        sat,
   output logic        err,
   output logic        busy,
   output logic        gen_ena,
   output logic        gen_start,
   input  logic [7:0]  gen_value,
   input  logic        gen_rdy
);

   localparam int unsigned NREQ = 4;
   localparam int unsigned IW   = 2;
   localparam int unsigned DW   = 8;
   localparam int unsigned CW   = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CHECK,
      S_STEP,
      S_DELIVER
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_sel;
   logic [CW-1:0]   r_retry;
   logic [CW-1:0]   r_wait;
   logic [NREQ-1:0] r_gnt;
   logic [DW-1:0]   r_value;
   logic            r_sat;
   logic            r_err;
   logic            r_busy;
   logic            r_gen_ena;

   state_t          w_state_nxt;
   logic [IW-1:0]   w_ptr_nxt;
   logic [IW-1:0]   w_sel_nxt;
   logic [CW-1:0]   w_retry_nxt;
   logic [CW-1:0]   w_wait_nxt;
   logic [NREQ-1:0] w_gnt_nxt;
   logic [DW-1:0]   w_value_nxt;
   logic            w_sat_nxt;
   logic            w_err_nxt;
   logic            w_busy_nxt;
   logic            w_gen_ena_nxt;

   logic            w_rr_hit;
   logic [IW-1:0]   w_rr_idx;
   logic [DW-1:0]   w_lim_sel;
   logic [NREQ-1:0] w_sel_onehot;

   // Round-robin search starting one past the last served requester
   always_comb begin
      w_rr_hit = 1'b0;
      w_rr_idx = r_ptr;
      for (int k = 1; k <= int'(NREQ); k++) begin
         if (!w_rr_hit && req[r_ptr + IW'(k)]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = r_ptr + IW'(k);
         end
      end
   end

   // Limit of the requester currently in service
   always_comb begin
      case (r_sel)
         2'd0:    w_lim_sel = lim[7:0];
         2'd1:    w_lim_sel = lim[15:8];
         2'd2:    w_lim_sel = lim[23:16];
         default: w_lim_sel = lim[31:24];
      endcase
      w_sel_onehot = NREQ'(1) << r_sel;
   end

   // Next-state and next-output logic; outputs land in registers below
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_retry_nxt = r_retry;
      w_wait_nxt  = r_wait;
      w_gnt_nxt   = '0;
      w_value_nxt = r_value;
      w_sat_nxt   = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_rr_hit) begin
               w_sel_nxt   = w_rr_idx;
               w_retry_nxt = '0;
               w_wait_nxt  = '0;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_wait_nxt = r_wait + CW'(1);
            if (gen_rdy) begin
               w_state_nxt = S_CHECK;
            end else if (r_wait == CW'(WAIT_MAX - 1)) begin
               w_state_nxt = S_DELIVER;
               w_gnt_nxt   = w_sel_onehot;
               w_value_nxt = '0;
               w_err_nxt   = 1'b1;
            end
         end
         S_CHECK: begin
            if (gen_value <= w_lim_sel) begin
               w_state_nxt = S_DELIVER;
               w_gnt_nxt   = w_sel_onehot;
               w_value_nxt = gen_value;
            end else if (r_retry < CW'(MAX_RETRY)) begin
               w_retry_nxt = r_retry + CW'(1);
               w_state_nxt = S_STEP;
            end else begin
               w_state_nxt = S_DELIVER;
               w_gnt_nxt   = w_sel_onehot;
               w_value_nxt = w_lim_sel;
               w_sat_nxt   = 1'b1;
            end
         end
         S_STEP: begin
            w_state_nxt = S_CHECK;
         end
         S_DELIVER: begin
            w_ptr_nxt   = r_sel;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_gen_ena_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= IW'(NREQ - 1);
         r_sel     <= '0;
         r_retry   <= '0;
         r_wait    <= '0;
         r_gnt     <= '0;
         r_value   <= '0;
         r_sat     <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_gen_ena <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sel     <= w_sel_nxt;
         r_retry   <= w_retry_nxt;
         r_wait    <= w_wait_nxt;
         r_gnt     <= w_gnt_nxt;
         r_value   <= w_value_nxt;
         r_sat     <= w_sat_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= w_busy_nxt;
         r_gen_ena <= w_gen_ena_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign value     = r_value;
   assign sat       = r_sat;
   assign err       = r_err;
   assign busy      = r_busy;
   assign gen_ena   = r_gen_ena;
   assign gen_start = r_gen_ena;

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter with a small behavioural generator model.
module tb_rng_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] lim = '1;
   logic [3:0]  gnt;
   logic [7:0]  value;
   logic        sat, err, busy, gen_ena, gen_start;
   logic [7:0]  gen_value = '0;
   logic        gen_rdy = 1'b0;

   rng_arbiter #(.MAX_RETRY(15), .WAIT_MAX(255)) dut (
      .clk(clk), .rst(rst), .req(req), .lim(lim), .gnt(gnt), .value(value),
      .sat(sat), .err(err), .busy(busy), .gen_ena(gen_ena), .gen_start(gen_start),
      .gen_value(gen_value), .gen_rdy(gen_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] g;
      logic [7:0] v;
      logic       s;
      logic       e;
      int         steps;
      int         ena;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // generator model state
   logic [7:0] vals[$];
   int   rdy_after  = 1;
   int   pulses     = 0;
   int   ena_cycles = 0;
   int   run_cnt    = 0;
   int   vi         = 0;
   logic prev_busy  = 1'b0;
   logic prev_ena   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [7:0] v, input logic s,
                           input logic e, input int steps, input int ena);
      exp_t x;
      x.g = g; x.v = v; x.s = s; x.e = e; x.steps = steps; x.ena = ena;
      sb.push_back(x);
   endtask

   task automatic wait_gnts(input int n, input int budget, input string name);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (gnt != 4'b0) seen++;
      end
      if (seen < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d grants expected %0d", name, seen, n);
      end
   endtask

   task automatic wait_busy(input int budget, input string name);
      int cyc = 0;
      while (!busy && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_busy_timeout: got busy=0 expected 1", name);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Generator: ready after rdy_after RUN cycles, one value step per STEP cycle
   always @(negedge clk) begin
      if (busy && !prev_busy) begin
         pulses     = 0;
         ena_cycles = 0;
         run_cnt    = 0;
         vi         = 0;
         gen_value  = vals[0];
      end
      if (gen_ena && !prev_ena) pulses++;
      if (gen_ena) ena_cycles++;
      if (gen_ena && pulses == 1) begin
         run_cnt++;
         gen_rdy = (run_cnt >= rdy_after);
      end else begin
         gen_rdy = 1'b0;
      end
      if (gen_ena && pulses >= 2 && vi + 1 < vals.size()) begin
         vi++;
         gen_value = vals[vi];
      end
      prev_busy = busy;
      prev_ena  = gen_ena;
   end

   // Monitor: compare each grant against the scoreboard head
   always @(negedge clk) begin
      if (rst && gnt != 4'b0) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_gnt: got gnt=%b expected no grant", gnt);
         end else begin
            mon_e = sb.pop_front();
            check("gnt",        32'(gnt),            32'(mon_e.g));
            check("value",      32'(value),          32'(mon_e.v));
            check("sat",        32'(sat),            32'(mon_e.s));
            check("err",        32'(err),            32'(mon_e.e));
            check("step_count", 32'(pulses - 1),     32'(mon_e.steps));
            check("ena_cycles", 32'(ena_cycles),     32'(mon_e.ena));
            check("busy_in_gnt", 32'(busy),          32'd1);
         end
      end
      if (gnt == 4'b0 && (sat || err)) begin
         n_tests++;
         n_fail++;
         $display("FAIL flag_outside_gnt: got sat=%b err=%b expected 0 0", sat, err);
      end
      if (gen_start !== gen_ena) begin
         n_tests++;
         n_fail++;
         $display("FAIL gen_start_eq_ena: got %b expected %b", gen_start, gen_ena);
      end
   end

   initial begin
      vals = '{8'h00};
      rst  = 1'b0;
      #12;
      check("rst_gnt",     32'(gnt),       32'h0);
      check("rst_value",   32'(value),     32'h0);
      check("rst_sat",     32'(sat),       32'h0);
      check("rst_err",     32'(err),       32'h0);
      check("rst_busy",    32'(busy),      32'h0);
      check("rst_gen_ena", 32'(gen_ena),   32'h0);
      check("rst_gen_st",  32'(gen_start), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // single request, generator ready after 11 RUN cycles
      lim = 32'hFFFF_FFFF; vals = '{8'h5A}; rdy_after = 11;
      push_exp(4'b0001, 8'h5A, 1'b0, 1'b0, 0, 11);
      req = 4'b0001;
      wait_gnts(1, 100, "single");
      req = 4'b0000;
      @(posedge clk); #1;
      check("single_busy_after", 32'(busy), 32'h0);
      check("single_gnt_after",  32'(gnt),  32'h0);
      repeat (2) @(posedge clk); #1;

      // round robin from reset pointer
      do_reset();
      vals = '{8'h21}; rdy_after = 1;
      push_exp(4'b0001, 8'h21, 1'b0, 1'b0, 0, 1);
      push_exp(4'b0010, 8'h21, 1'b0, 1'b0, 0, 1);
      push_exp(4'b0100, 8'h21, 1'b0, 1'b0, 0, 1);
      push_exp(4'b1000, 8'h21, 1'b0, 1'b0, 0, 1);
      req = 4'b1111;
      wait_gnts(4, 200, "rr_all");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;
      push_exp(4'b0001, 8'h21, 1'b0, 1'b0, 0, 1);
      push_exp(4'b0100, 8'h21, 1'b0, 1'b0, 0, 1);
      req = 4'b0101;
      wait_gnts(2, 200, "rr_0101");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;

      // two rejections then accept; request dropped right after selection
      lim = 32'hFFFF_10FF; vals = '{8'h80, 8'h40, 8'h08}; rdy_after = 1;
      push_exp(4'b0010, 8'h08, 1'b0, 1'b0, 2, 3);
      req = 4'b0010;
      wait_busy(20, "reject2");
      req = 4'b0000;
      wait_gnts(1, 100, "reject2");
      repeat (3) @(posedge clk); #1;

      // lim 0x00 never satisfied: retry budget exhausted, clamped
      lim = 32'hFF00_FFFF; vals = '{8'h33};
      push_exp(4'b0100, 8'h00, 1'b1, 1'b0, 15, 16);
      req = 4'b0100;
      wait_gnts(1, 200, "saturate");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;

      // generator never ready: timeout
      lim = 32'hFFFF_FFFF; vals = '{8'h77}; rdy_after = 100000;
      push_exp(4'b0001, 8'h00, 1'b0, 1'b1, 0, 255);
      req = 4'b0001;
      wait_gnts(1, 400, "timeout");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;

      // lim 0xFF accepts 0xFF immediately
      vals = '{8'hFF}; rdy_after = 1;
      push_exp(4'b1000, 8'hFF, 1'b0, 1'b0, 0, 1);
      req = 4'b1000;
      wait_gnts(1, 100, "lim_ff");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;

      // lim 0x00 accepts 0x00 immediately
      lim = 32'hFF00_FFFF; vals = '{8'h00};
      push_exp(4'b0100, 8'h00, 1'b0, 1'b0, 0, 1);
      req = 4'b0100;
      wait_gnts(1, 100, "lim_00");
      req = 4'b0000;
      repeat (3) @(posedge clk); #1;

      // reset during RUN aborts service; still-held request restarts
      lim = 32'hFFFF_FFFF; vals = '{8'h44}; rdy_after = 100000;
      req = 4'b0001;
      wait_busy(20, "abort");
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("abort_gen_ena", 32'(gen_ena), 32'h0);
      check("abort_busy",    32'(busy),    32'h0);
      check("abort_gnt",     32'(gnt),     32'h0);
      rdy_after = 1;
      repeat (2) @(negedge clk);
      push_exp(4'b0001, 8'h44, 1'b0, 1'b0, 0, 1);
      rst = 1'b1;
      wait_gnts(1, 100, "restart");
      req = 4'b0000;
      repeat (5) @(posedge clk); #1;

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
